trig_phase_align: RTL

Parametrised per-channel trigger re-timer for the trigger distribution board, running on `clk_adc`. During a calibration window it learns, per input channel, which of `N_PH` clock phases the remote board's sync pulses arrive in. Outside the window it re-times locked triggers onto a common phase and stretches them. It also keeps per-channel trigger and error counters for monitoring readout.

---
 rtl/trig_phase_align.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/trig_phase_align.sv
`default_nettype none
// ============================================================================
// Module   : trig_phase_align
// Brief    : Learns the arrival phase of each channel's sync pulses during a
//            calibration window, then re-times and stretches locked triggers.
// Revision : 1.0 - initial release
// ============================================================================
module trig_phase_align #(
    parameter int N_CH     = 16,
    parameter int N_PH     = 4,
    parameter int SETTLE   = 200,
    parameter int LOCK_MIN = 54,
    parameter int STRETCH  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_adc,
    input  logic                         rst,
    input  logic                         clk_locked,
    input  logic [N_CH-1:0]              coax_in,
    input  logic                         cal_window,
    input  logic [N_CH-1:0]              align_en,
    output logic [N_CH-1:0]              trig_out,
    output logic [N_CH-1:0]              locked,
    output logic [N_CH*$clog2(N_PH)-1:0] phase,
    input  logic [$clog2(N_CH):0]        cnt_sel,
    input  logic                         cnt_clr,
    output logic [CNT_W-1:0]             cnt_out
);
    localparam int c_ph_w   = $clog2(N_PH);
    localparam int c_ch_w   = $clog2(N_CH);
    localparam int c_hold_w = $clog2(STRETCH * N_PH + 1);
    localparam int c_set_w  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_hold_w-1:0] c_hold_len    = c_hold_w'(STRETCH * N_PH);
    localparam logic [c_set_w-1:0]  c_settle_last = c_set_w'(SETTLE - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max     = '1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_count  = 2'd2;
    localparam logic [1:0] c_st_eval   = 2'd3;

    logic [N_CH-1:0]     r_s;
    logic [c_ph_w-1:0]   r_pc;
    logic [1:0]          r_state;
    logic                r_cal_d;
    logic [c_set_w-1:0]  r_settle_cnt;
    logic [7:0]          r_bin [N_PH][N_CH];
    logic [N_CH-1:0]     r_locked;
    logic [c_ph_w-1:0]   r_phase [N_CH];
    logic [N_CH-1:0]     r_pend;
    logic [c_hold_w-1:0] r_hold [N_CH];
    logic [N_CH-1:0]     r_trig;
    logic [CNT_W-1:0]    r_trg_cnt [N_CH];
    logic [CNT_W-1:0]    r_unl_cnt [N_CH];
    logic [CNT_W-1:0]    r_cnt_out;

    logic                w_idle;
    logic [N_CH-1:0]     w_lock_ok;
    logic [c_ph_w-1:0]   w_lock_ph [N_CH];
    logic [N_CH-1:0]     w_pend_nxt;
    logic [c_hold_w-1:0] w_hold_nxt [N_CH];
    logic [c_ch_w-1:0]   w_sel_ch;

    assign w_idle   = (r_state == c_st_idle);
    assign w_sel_ch = cnt_sel[c_ch_w-1:0];

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_s  <= '0;
            r_pc <= '0;
        end else begin
            r_s  <= clk_locked ? coax_in : '0;
            r_pc <= r_pc + 1'b1;
        end
    end

    // A channel locks only when exactly one bin saw pulses and that bin is well populated.
    always_comb begin
        logic [4:0] w_nz;
        logic       w_big;
        w_lock_ok = '0;
        w_nz      = '0;
        w_big     = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            w_nz          = '0;
            w_big         = 1'b0;
            w_lock_ph[ch] = '0;
            for (int b = 0; b < N_PH; b++) begin
                if (r_bin[b][ch] != 8'd0) begin
                    w_nz          = w_nz + 5'd1;
                    w_big         = (int'(r_bin[b][ch]) >= LOCK_MIN);
                    w_lock_ph[ch] = c_ph_w'(b);
                end
            end
            w_lock_ok[ch] = (w_nz == 5'd1) && w_big;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cal_d      <= 1'b0;
            r_settle_cnt <= '0;
            r_locked     <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                r_phase[ch] <= '0;
                for (int b = 0; b < N_PH; b++) r_bin[b][ch] <= '0;
            end
        end else begin
            r_cal_d <= cal_window;
            case (r_state)
                c_st_idle: begin
                    if (cal_window && !r_cal_d) begin
                        for (int ch = 0; ch < N_CH; ch++)
                            for (int b = 0; b < N_PH; b++) r_bin[b][ch] <= '0;
                        r_settle_cnt <= '0;
                        r_state      <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (!cal_window)                       r_state <= c_st_eval;
                    else if (r_settle_cnt == c_settle_last) r_state <= c_st_count;
                    else                                    r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                c_st_count: begin
                    if (!cal_window) begin
                        r_state <= c_st_eval;
                    end else begin
                        for (int ch = 0; ch < N_CH; ch++)
                            if (r_s[ch] && r_bin[r_pc][ch] != 8'hFF)
                                r_bin[r_pc][ch] <= r_bin[r_pc][ch] + 8'd1;
                    end
                end
                c_st_eval: begin
                    r_locked <= w_lock_ok;
                    for (int ch = 0; ch < N_CH; ch++)
                        r_phase[ch] <= w_lock_ok[ch] ? w_lock_ph[ch] : '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Pending triggers wait for the phase-0 slot; a reload simply restarts the stretch.
    always_comb begin
        w_pend_nxt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            w_pend_nxt[ch] = r_pend[ch] | (r_s[ch] & r_locked[ch]);
            if (!w_idle || !align_en[ch])
                w_hold_nxt[ch] = '0;
            else if (w_pend_nxt[ch] && r_pc == '0)
                w_hold_nxt[ch] = c_hold_len;
            else if (r_hold[ch] != '0)
                w_hold_nxt[ch] = r_hold[ch] - 1'b1;
            else
                w_hold_nxt[ch] = '0;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_pend <= '0;
            r_trig <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                r_hold[ch]    <= '0;
                r_trg_cnt[ch] <= '0;
                r_unl_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r_hold[ch] <= w_hold_nxt[ch];
                r_pend[ch] <= w_idle && align_en[ch] && (r_pc != '0) && w_pend_nxt[ch];
                r_trig[ch] <= w_idle && (align_en[ch] ? (w_hold_nxt[ch] != '0) : r_s[ch]);
                if (cnt_clr) begin
                    r_trg_cnt[ch] <= '0;
                    r_unl_cnt[ch] <= '0;
                end else begin
                    if (w_idle && r_s[ch] && (r_locked[ch] || !align_en[ch]) &&
                        r_trg_cnt[ch] != c_cnt_max)
                        r_trg_cnt[ch] <= r_trg_cnt[ch] + 1'b1;
                    if (w_idle && r_s[ch] && align_en[ch] && !r_locked[ch] &&
                        r_unl_cnt[ch] != c_cnt_max)
                        r_unl_cnt[ch] <= r_unl_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst)                         r_cnt_out <= '0;
        else if (int'(w_sel_ch) >= N_CH) r_cnt_out <= '0;
        else if (cnt_sel[c_ch_w])        r_cnt_out <= r_unl_cnt[w_sel_ch];
        else                             r_cnt_out <= r_trg_cnt[w_sel_ch];
    end

    always_comb begin
        phase = '0;
        for (int ch = 0; ch < N_CH; ch++) phase[ch*c_ph_w +: c_ph_w] = r_phase[ch];
    end

    assign trig_out = r_trig;
    assign locked   = r_locked;
    assign cnt_out  = r_cnt_out;
endmodule
`default_nettype wire
